muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32IM M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses an iterative shift-add multiplier and a restoring divider, both on operand magnitudes, plus a final sign-fix step.
- Sits beside the single-cycle EX-stage ALU. The pipeline controller raises START for M-ops and stalls on BUSY until VALID.

---
 rtl/muldiv_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32IM M-extension unit: shift-add multiplier and restoring divider on
// operand magnitudes, followed by a one-cycle sign fix. Optional MULDIV_EARLY_OUT_EN skips CALC for trivial operands.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT
);

    // state  | meaning
    // IDLE   | waiting for START with a valid M-op select
    // CALC   | one multiply/divide iteration per cycle, WIDTH cycles
    // FIX    | sign correction and output word select
    // DONE   | VALID pulse, RESULT updated; accepts a back-to-back START
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg_q;
    logic             div0_q;
    logic             ovf_q;
    logic             zero_q;

    logic             sel_ok;
    logic             start_ok;
    logic [2:0]       op_in;
    logic             is_div_in;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div0_in;
    logic             ovf_in;
    logic             zero_in;
    logic             neg_in;
    logic [1:0]       first_state;

    assign sel_ok    = (SELECT[4:3] == 2'b01);
    assign start_ok  = START && sel_ok;
    assign op_in     = SELECT[2:0];
    assign is_div_in = op_in[2];
    assign a_signed  = (op_in == 3'b001) || (op_in == 3'b010) || (op_in[2:1] == 2'b10);
    assign b_signed  = (op_in == 3'b001) || (op_in[2:1] == 2'b10);
    assign a_neg     = a_signed && DATA1[WIDTH-1];
    assign b_neg     = b_signed && DATA2[WIDTH-1];
    assign a_mag     = a_neg ? -DATA1 : DATA1;
    assign b_mag     = b_neg ? -DATA2 : DATA2;
    assign div0_in   = is_div_in && (DATA2 == '0);
    assign ovf_in    = is_div_in && !op_in[1] && (DATA1 == MOST_NEG) && (DATA2 == '1);
    assign zero_in   = !is_div_in && ((DATA1 == '0) || (DATA2 == '0));
    // Remainder follows the dividend's sign; quotient and product follow the sign XOR.
    assign neg_in    = (is_div_in && op_in[0]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_EARLY_OUT_EN
    assign first_state = (div0_in || ovf_in || zero_in) ? S_FIX : S_CALC;
`else
    assign first_state = S_CALC;
`endif

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_sh_low;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    assign mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Shifted partial remainder is {hi, lo[msb]}; hi[msb] set means it already exceeds any divisor.
    assign div_sh_low = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign div_ge     = hi[WIDTH-1] || (div_sh_low >= opnd);
    assign div_sub    = div_sh_low - opnd;

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        if (op[2]) begin
            hi_nx = div_ge ? div_sub : div_sh_low;
            lo_nx = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   fix_res;

    assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
    assign q_s    = neg_q ? -lo : lo;
    assign r_s    = neg_q ? -hi : hi;

    always_comb begin
        fix_res = '0;
        if (!op[2]) begin
            if (zero_q)
                fix_res = '0;
            else if (op[1:0] == 2'b00)
                fix_res = prod_s[WIDTH-1:0];
            else
                fix_res = prod_s[2*WIDTH-1:WIDTH];
        end else if (div0_q) begin
            fix_res = op[0] ? a_raw : '1;
        end else if (ovf_q) begin
            fix_res = op[0] ? '0 : MOST_NEG;
        end else begin
            fix_res = op[0] ? r_s : q_s;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op     <= '0;
            a_raw  <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            RESULT <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state  <= first_state;
                        cnt    <= '0;
                        op     <= op_in;
                        a_raw  <= DATA1;
                        opnd   <= is_div_in ? b_mag : a_mag;
                        lo     <= is_div_in ? a_mag : b_mag;
                        hi     <= '0;
                        neg_q  <= neg_in;
                        div0_q <= div0_in;
                        ovf_q  <= ovf_in;
                        zero_q <= zero_in;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (FLUSH) begin
                        state <= S_IDLE;
                    end else begin
                        hi <= hi_nx;
                        lo <= lo_nx;
                        if (cnt == CNT_LAST)
                            state <= S_FIX;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (FLUSH) begin
                        state <= S_IDLE;
                    end else begin
                        RESULT <= fix_res;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY  = (state == S_CALC) || (state == S_FIX);
    assign VALID = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for results and latency,
// plus hand sequences for back-to-back, FLUSH, invalid select and async reset.
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_REM    = 5'b01101;
    localparam logic [4:0] OP_DIVU   = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [4:0]  SELECT = 5'b0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        FLUSH = 1'b0;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issues one op and counts edges from the START edge (edge 1) to the VALID edge.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt,
                          output logic valid_after);
        logic got;
        @(negedge CLK);
        START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
        @(posedge CLK);
        lat = 1;
        #1;
        busy_cnt = BUSY ? 1 : 0;
        got = VALID;
        @(negedge CLK);
        START = 1'b0; DATA1 = ~a; DATA2 = b ^ 32'h5A5A_A5A5;
        while (!got && lat < 100) begin
            @(posedge CLK);
            lat++;
            #1;
            if (BUSY) busy_cnt++;
            got = VALID;
        end
        res = RESULT;
        @(posedge CLK);
        #1;
        valid_after = VALID;
    endtask

    task automatic wait_valid(output int at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            #1;
            if (VALID) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          busy_cnt;
        logic        vafter;
        int          exp_lat;
        int          v1;
        int          v2;
        bit          ok1;
        bit          ok2;
        bit          seen;

        vecs[0]  = '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[1]  = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[3]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{OP_MUL,    32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0};
        vecs[6]  = '{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
        vecs[8]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[9]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
        vecs[13] = '{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0};
        vecs[14] = '{OP_MUL,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[15] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
        vecs[16] = '{OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[17] = '{OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};

        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_valid", {31'b0, VALID}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 18; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
            exp_lat = vecs[i].spec ? 2 : 34;
`else
            exp_lat = 34;
`endif
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat, busy_cnt, vafter);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, exp_lat - 1);
            check($sformatf("vec%0d_valid_pulse", i), {31'b0, vafter}, 32'd0);
        end

        // Back-to-back: second START lands in the DONE cycle; a mid-CALC START is ignored.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd4;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        wait_valid(v1, ok1);
        check("b2b_first_valid", {31'b0, ok1}, 32'd1);
        check("b2b_first_result", RESULT, 32'h0000_000C);
        @(negedge CLK);
        START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
        @(posedge CLK);
        #1;
        check("b2b_busy_after_restart", {31'b0, BUSY}, 32'd1);
        @(negedge CLK);
        START = 1'b0; DATA1 = 32'd0; DATA2 = 32'd0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; SELECT = OP_MUL; DATA1 = 32'd9; DATA2 = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        wait_valid(v2, ok2);
        check("b2b_second_valid", {31'b0, ok2}, 32'd1);
        check("b2b_second_result", RESULT, 32'h0000_000E);
        check("b2b_valid_spacing", v2 - v1, 32'd34);

        // FLUSH at CALC cycle 10 of a DIV.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_DIV; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        check("flush_busy_low", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        FLUSH = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (VALID || BUSY) seen = 1'b1;
        end
        check("flush_no_valid", {31'b0, seen}, 32'd0);
        check("flush_result_kept", RESULT, 32'h0000_000E);

        // Out-of-range selects are ignored.
        @(negedge CLK);
        START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd6; DATA2 = 32'd7;
        @(posedge CLK);
        #1;
        check("bad_sel0_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        SELECT = 5'b10000;
        @(posedge CLK);
        #1;
        check("bad_sel16_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("bad_sel_no_valid", {31'b0, VALID}, 32'd0);

        // Asynchronous reset between edges mid-CALC.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_MUL; DATA1 = 32'd7; DATA2 = 32'd9;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, BUSY}, 32'd0);
        check("async_rst_valid", {31'b0, VALID}, 32'd0);
        check("async_rst_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        run_op(OP_MUL, 32'd2, 32'd3, res, lat, busy_cnt, vafter);
        check("post_rst_mul_result", res, 32'h0000_0006);
        check("post_rst_mul_latency", lat, 32'd34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
